// File: rtl/gpo_dispatch_pkg.sv
// Shared types and constants for the timed-GPO dispatch path.
package gpo_dispatch_pkg;
  localparam int TS_W  = 64;
  localparam int VAL_W = 64;
  localparam int CMD_W = TS_W + VAL_W;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [VAL_W-1:0] value;
  } gpo_cmd_t;

  localparam int ERR_BUSY = 0;
  localparam int ERR_OVR  = 1;
  localparam int ERR_LATE = 2;
  localparam int ERR_OVF  = 3;
  localparam int ERR_W    = 4;
endpackage

// File: rtl/gpo_cmd_fifo.sv
// Command FIFO with show-ahead front; the dispatcher's head register is the registered read stage.
module gpo_cmd_fifo
  import gpo_dispatch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  gpo_cmd_t         wr_data,
  input  logic             rd_en,
  output gpo_cmd_t         rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  gpo_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty && !flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_wr   = wr_en && !flush && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count define validity,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge CLK100MHZ) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK100MHZ) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end
endmodule

// File: rtl/gpo_timed_dispatcher.sv
// Timestamp-matched command dispatcher feeding the GPO core, with first-error capture.
module gpo_timed_dispatcher
  import gpo_dispatch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_W    = 5
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [CMD_W-1:0]   wr_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] fifo_level,
  input  logic               enable,
  input  logic               flush,
  input  logic [TS_W-1:0]    counter,
  output logic               counter_matched,
  output logic [CMD_W-1:0]   gpo_in,
  input  logic               busy_error,
  input  logic               overrided,
  input  logic [CMD_W-1:0]   error_data,
  input  logic               err_clear,
  output logic [ERR_W-1:0]   err_flags,
  output logic [CMD_W-1:0]   err_capture,
  output logic [15:0]        late_count
);
  gpo_cmd_t           head;
  gpo_cmd_t           fifo_front;
  gpo_cmd_t           wr_cmd;
  logic               head_valid;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_count;
  logic               pop;
  logic               eval;
  logic               hit;
  logic               late;
  logic               ovf;
  logic [ERR_W-1:0]   new_flags;
  logic [CMD_W-1:0]   new_payload;

  assign wr_cmd = wr_data;

  gpo_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (LEVEL_W)
  ) u_fifo (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (wr_cmd),
    .rd_en     (pop),
    .rd_data   (fifo_front),
    .full      (full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign empty      = fifo_empty && !head_valid;
  assign fifo_level = fifo_count + LEVEL_W'(head_valid);

  // Flush kills both the refill and any compare result of this cycle.
  assign pop  = !head_valid && !fifo_empty && !flush;
  assign eval = enable && head_valid && !flush;
  assign hit  = eval && (head.ts == counter);
  assign late = eval && (head.ts < counter);
  assign ovf  = wr_en && full && !pop && !flush;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    new_flags           = '0;
    new_flags[ERR_BUSY] = busy_error;
    new_flags[ERR_OVR]  = overrided;
    new_flags[ERR_LATE] = late;
    new_flags[ERR_OVF]  = ovf;
    new_payload         = wr_data;
    if (busy_error || overrided) new_payload = error_data;
    else if (late)               new_payload = head;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      head            <= '0;
      head_valid      <= 1'b0;
      counter_matched <= 1'b0;
      gpo_in          <= '0;
    end else begin
      counter_matched <= hit;
      if (hit) gpo_in <= head;
      if (flush) begin
        head_valid <= 1'b0;
      end else if (pop) begin
        head       <= fifo_front;
        head_valid <= 1'b1;
      end else if (hit || late) begin
        head_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      err_flags   <= '0;
      err_capture <= '0;
      late_count  <= '0;
    end else if (err_clear) begin
      err_flags   <= new_flags;
      err_capture <= (|new_flags) ? new_payload : '0;
      late_count  <= late ? 16'd1 : 16'd0;
    end else begin
      err_flags <= err_flags | new_flags;
      if (err_flags == '0 && |new_flags) err_capture <= new_payload;
      if (late && late_count != 16'hFFFF) late_count <= late_count + 16'd1;
    end
  end
endmodule
